// File: rtl/program_sequencer.sv
// program_sequencer: steps a host-loaded program through the control unit one
// instruction at a time (issue pulse, wait for done), with halt-word detection,
// graceful stop, a done-watchdog and a saturating executed-instruction counter.
// Optional feature macro: SEQ_LOOP_EN (program repeats from pc=0 until stop,
// halt word or watchdog instead of finishing at the last instruction).
module program_sequencer #(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 64,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stop,
  input  logic          cu_done,
  output logic [15:0]   cu_instruction,
  output logic          cu_run,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic [15:0]   exec_count,
  output logic          finished,
  output logic          error
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t        r_state, w_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [AW:0]   r_len;
  logic [15:0]   r_instr, r_exec, w_fetch;
  logic [WW-1:0] r_wd;
  logic          r_run, r_halt, r_stop, r_fin, r_err;
  logic          w_busy, w_accept, w_zero, w_last, w_stop_pend;

  assign w_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_stop_pend = r_stop || stop;
  assign w_last      = ({1'b0, r_pc} + (AW+1)'(1)) == r_len;

  // The word for the next ISSUE is fetched at the edge entering ISSUE so that
  // cu_run and cu_instruction are both registered and aligned. A host write
  // landing on that same edge is forwarded so ISSUE sees the new word.
  assign w_fetch = (load_en && !w_busy && (load_addr == w_pc_nxt)) ? load_data
                                                                   : r_mem[w_pc_nxt];

  // Program memory: host writes only while idle; contents are not reset.
  always_ff @(posedge clk)
    if (load_en && !w_busy) r_mem[load_addr] <= load_data;

  // Next-state and next-pc decision.
  always_comb begin
    w_nxt    = r_state;
    w_pc_nxt = r_pc;
    w_accept = 1'b0;
    w_zero   = 1'b0;
    case (r_state)
      S_IDLE, S_ERR: if (start) begin
        w_accept = 1'b1;
        if (prog_len == '0) begin
          w_zero = 1'b1;
          w_nxt  = S_IDLE;
        end else begin
          w_nxt    = S_ISSUE;
          w_pc_nxt = '0;
        end
      end
      S_ISSUE: w_nxt = r_halt ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (cu_done) begin
          if (w_stop_pend) begin
            w_nxt = S_DONE;
          end else if (w_last) begin
`ifdef SEQ_LOOP_EN
            w_nxt    = S_ISSUE;
            w_pc_nxt = '0;
`else
            w_nxt = S_DONE;
`endif
          end else begin
            w_nxt    = S_ISSUE;
            w_pc_nxt = r_pc + 1'b1;
          end
        end else if (r_wd == WW'(TIMEOUT - 1)) begin
          w_nxt = S_ERR;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, datapath registers, counters and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_instr <= '0;
      r_exec  <= '0;
      r_wd    <= '0;
      r_run   <= 1'b0;
      r_halt  <= 1'b0;
      r_stop  <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_pc    <= w_pc_nxt;
      r_fin   <= w_zero || (w_nxt == S_DONE);
      r_run   <= 1'b0;
      if (w_nxt == S_ISSUE) begin
        r_halt <= (w_fetch == 16'hFFFF);
        if (w_fetch != 16'hFFFF) begin
          r_run   <= 1'b1;
          r_instr <= w_fetch;
        end
      end
      if (w_accept) begin
        r_exec <= '0;
        r_err  <= 1'b0;
        if (!w_zero) r_len <= prog_len;
      end else if (r_state == S_WAIT && cu_done && r_exec != 16'hFFFF) begin
        r_exec <= r_exec + 16'd1;
      end
      if (r_state == S_WAIT && w_nxt == S_ERR) r_err <= 1'b1;
      // watchdog only counts idle WAIT cycles; any other state rearms it
      if (r_state == S_WAIT && !cu_done) r_wd <= r_wd + 1'b1;
      else                               r_wd <= '0;
      if (w_nxt == S_IDLE || w_nxt == S_ERR) r_stop <= 1'b0;
      else if (w_busy && stop)               r_stop <= 1'b1;
    end
  end

  assign cu_instruction = r_instr;
  assign cu_run         = r_run;
  assign busy           = w_busy;
  assign pc             = r_pc;
  assign exec_count     = r_exec;
  assign finished       = r_fin;
  assign error          = r_err;
endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: reset values, a table of directed
// program runs, randomized runs against a transaction-level reference model,
// and hand-written sequences for reset and loop mode.
module tb_program_sequencer;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int AW      = 4;

  logic          clk = 1'b0, reset = 1'b0;
  logic          load_en = 1'b0, start = 1'b0, stop = 1'b0, cu_done = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic [15:0]   cu_instruction, exec_count;
  logic          cu_run, busy, finished, error;
  logic [AW-1:0] pc;

  int n_cmp = 0, n_bad = 0;

  // Host-side image of program memory and per-run stimulus knobs.
  logic [15:0] img [DEPTH];
  int          dly [256];   // cu_done delay per issued instruction, 0 = never
  int          stop_k = -1; // issue index during which stop is raised
  bit          ld_busy = 0, ld_start = 0;
  logic [15:0] ld_start_word = 16'h0;
  int          exp_n, exp_iss, last_fin_rel;
  bit          exp_err;

  program_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .stop(stop),
    .cu_done(cu_done), .cu_instruction(cu_instruction), .cu_run(cu_run),
    .busy(busy), .pc(pc), .exec_count(exec_count), .finished(finished),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    step();
    load_en = 1'b0;
    img[a] = d;
  endtask

  // Reference: walk the program as a list of instructions. Each one is either
  // a halt word (end, not issued), issued and never answered (error), or issued
  // and completed; a stop request ends the run after its instruction completes.
  task automatic model(input int len);
    exp_n = 0; exp_iss = 0; exp_err = 0;
    for (int k = 0; k < len; k++) begin
      if (img[k] == 16'hFFFF) break;
      exp_iss++;
      if (dly[k] == 0) begin exp_err = 1; break; end
      exp_n++;
      if (k == stop_k) break;
    end
  endtask

  // Launch one program and act as the control unit until finished or error.
  task automatic run_case(input string tag, input int len, input int e_n,
                          input int e_iss, input bit e_fin, input bit e_err);
    int rel, k, fins, xruns, xfins;
    bit err_seen, done;
    logic [15:0] got[$];
    if (ld_start) img[0] = ld_start_word;
    prog_len = (AW+1)'(len); start = 1'b1;
    if (ld_start) begin load_en = 1'b1; load_addr = '0; load_data = ld_start_word; end
    step();
    start = 1'b0; load_en = 1'b0;
    chk({tag, "_err_clr"}, error, 0);
    k = -1; rel = 0; fins = 0; err_seen = 0; done = 0; last_fin_rel = -1;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (cu_run) begin
        if (k >= 0) chk({tag, "_spacing"}, rel, dly[k] + 1);
        k++;
        got.push_back(cu_instruction);
        chk({tag, "_pc"}, pc, k % len);
        rel = 0;
      end
      if (finished) begin fins++; last_fin_rel = rel; done = 1; end
      if (error) begin err_seen = 1; chk({tag, "_err_time"}, rel, TIMEOUT + 1); done = 1; end
      cu_done   = (k >= 0 && rel > 0 && rel == dly[k]);
      stop      = (k >= 0 && k == stop_k && rel == ((dly[k] > 1) ? 1 : 0));
      load_en   = ld_busy && k == 0 && rel == 1;
      load_addr = '0; load_data = 16'hAAAA;
      if (!done) begin step(); rel++; end
    end
    cu_done = 1'b0; stop = 1'b0; load_en = 1'b0;
    chk({tag, "_terminated"}, done, 1);
    xruns = 0; xfins = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (cu_run) xruns++;
      if (finished) xfins++;
    end
    chk({tag, "_issues"}, got.size(), e_iss);
    for (int i = 0; i < got.size() && i < e_iss; i++)
      chk({tag, "_word"}, got[i], img[i % len]);
    chk({tag, "_exec_count"}, exec_count, e_n);
    chk({tag, "_finished"}, fins + xfins, e_fin);
    chk({tag, "_error"}, err_seen, e_err);
    chk({tag, "_error_sticky"}, error, e_err);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_extra_run"}, xruns, 0);
  endtask

  typedef struct {
    string tag; int len; int d; int stop_k; int halt_at; bit ld_busy; bit ld_start;
    int e_n; int e_iss; bit e_fin; bit e_err;
  } row_t;

  initial begin
    row_t tbl[11];
    int   len, a;
    logic [15:0] orig;

    // reset values
    step(); step();
    chk("rst_cu_instruction", cu_instruction, 0);
    chk("rst_cu_run", cu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    chk("rst_exec_count", exec_count, 0);
    chk("rst_finished", finished, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    step();

    load(0, 16'h2048); load(1, 16'h4410); load(2, 16'h6C20);
    for (int i = 3; i < DEPTH; i++) load(i, 16'h1000 + 16'(i * 16'h0111));

`ifdef SEQ_LOOP_EN
    // loop mode: two-word program repeats until stop during the 5th issue
    for (int k = 0; k < 256; k++) dly[k] = 3;
    stop_k = 4; ld_busy = 0; ld_start = 0;
    run_case("loop", 2, 5, 5, 1, 0);
`else
    //          tag        len d        stop halt lb ls  n  iss fin err
    tbl[0]  = '{"three",    3, 3,        -1,  -1, 0, 0,  3,  3, 1, 0};
    tbl[1]  = '{"halt",     4, 3,        -1,   1, 0, 0,  1,  1, 1, 0};
    tbl[2]  = '{"wdog",     3, 0,        -1,  -1, 0, 0,  0,  1, 0, 1};
    tbl[3]  = '{"rerun",    3, 2,        -1,  -1, 0, 0,  3,  3, 1, 0};
    tbl[4]  = '{"stop",     4, 3,         0,  -1, 0, 0,  1,  1, 1, 0};
    tbl[5]  = '{"ldbusy",   2, 4,        -1,  -1, 1, 0,  2,  2, 1, 0};
    tbl[6]  = '{"after_ld", 1, 1,        -1,  -1, 0, 0,  1,  1, 1, 0};
    tbl[7]  = '{"zero",     0, 1,        -1,  -1, 0, 0,  0,  0, 1, 0};
    tbl[8]  = '{"edge_to",  2, TIMEOUT,  -1,  -1, 0, 0,  2,  2, 1, 0};
    tbl[9]  = '{"full",    16, 1,        -1,  -1, 0, 0, 16, 16, 1, 0};
    tbl[10] = '{"ldstart",  2, 2,        -1,  -1, 0, 1,  2,  2, 1, 0};
    ld_start_word = 16'h5A5A;

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 256; k++) dly[k] = tbl[i].d;
      stop_k = tbl[i].stop_k; ld_busy = tbl[i].ld_busy; ld_start = tbl[i].ld_start;
      orig = 16'h0;
      if (tbl[i].halt_at >= 0) begin
        orig = img[tbl[i].halt_at];
        load(tbl[i].halt_at, 16'hFFFF);
      end
      run_case(tbl[i].tag, tbl[i].len, tbl[i].e_n, tbl[i].e_iss, tbl[i].e_fin, tbl[i].e_err);
      if (tbl[i].halt_at >= 0) load(tbl[i].halt_at, orig);
      if (i == 0) chk("three_finish_latency", last_fin_rel, 4);
    end
    ld_start = 0;

    // randomized programs against the reference model
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 3; j++) begin
        a = $urandom_range(0, DEPTH - 1);
        load(a, ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
      end
      len = $urandom_range(0, DEPTH);
      for (int k = 0; k < 256; k++)
        dly[k] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      stop_k  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
      ld_busy = 1'($urandom_range(0, 1));
      model(len);
      run_case("rnd", len, exp_n, exp_iss, !exp_err, exp_err);
    end

    // reset in the middle of a program drops everything immediately
    for (int k = 0; k < 256; k++) dly[k] = 5;
    load(0, 16'h2048);
    prog_len = 3; start = 1'b1;
    step();
    start = 1'b0;
    chk("midrst_run_before", cu_run, 1);
    reset = 1'b0;
    #1;
    chk("midrst_cu_run", cu_run, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cu_instruction", cu_instruction, 0);
    chk("midrst_pc", pc, 0);
    step();
    reset = 1'b1;
    step();
    chk("midrst_idle_busy", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
